fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Initiator side of the core's synchronous memory port: generates PC, issues read strobes, captures returned words, and hands them to decode over a valid/ready handshake.
- Holds a small prefetch FIFO so the one-cycle memory read latency does not stall decode.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.
- Sits between the memory block and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, increment applied to fetch PC per issued read.
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  Core clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- fetch_en  input  1  Permits new read issues; in-flight reads still complete.
- redirect_valid  input  1  One-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  32  New fetch address.
- mem_pc  output  32  Memory address, the full byte PC driven unmodified.
- mem_rd  output  1  Read strobe; data returns on mem_rdata the following cycle.
- mem_wr  output  1  Held 0; this block never writes.
- mem_wdata  output  32  Held 0.
- mem_rdata  input  32  Memory read data.
- instr_valid  output  1  FIFO head valid.
- instr_data  output  32  Instruction at FIFO head.
- instr_pc  output  32  PC of the instruction at FIFO head.
- instr_ready  input  1  Decode accepts the head this cycle.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0; state = IDLE.
  - instr_valid = 0, mem_rd = 0, mem_wr = 0, mem_wdata = 0.
  - instr_data and instr_pc reset to 0.
- States:
  - IDLE: no issue. Moves to RUN when fetch_en = 1.
  - RUN: issues reads. Returns to IDLE when fetch_en = 0.
  - redirect_valid does not change state.
- Issue condition (combinational), mem_rd = state==RUN && fetch_en && !redirect_valid && (count + inflight − pop) < DEPTH, where pop = instr_valid && instr_ready.
- mem_pc always equals fetch_pc. On issue, fetch_pc += PC_STEP (32-bit wrap, no overflow flag).
- Latency:
  - A read issued in cycle n sets inflight, with its PC recorded in inflight_pc.
  - mem_rdata is valid in cycle n+1 and is pushed {mem_rdata, inflight_pc} at the end of n+1.
  - instr_valid rises in n+2 at the earliest. First fetch after reset appears 3 cycles after rst release when fetch_en is already 1.
- Throughput: with instr_ready held high, one instruction per cycle in steady state.
- FIFO:
  - Circular with wrapping rd/wr pointers and count 0..DEPTH.
  - Push and pop in the same cycle at count==DEPTH is legal; the credit term in the issue condition guarantees no overflow.
  - A push into an empty FIFO is not forwarded combinationally.
- Redirect (highest priority, cycle r):
  - No issue in r.
  - Any response arriving in r is discarded; inflight cleared.
  - FIFO flushed (count = 0); a pop in r is ignored for pointer purposes.
  - fetch_pc = redirect_pc; instr_valid = 0 from r+1.
  - First read at redirect_pc is issued in r+1 if state is RUN.
  - Back-to-back redirects: the last one wins.
- fetch_en low mid-stream: issuing stops immediately; the outstanding response is still captured; FIFO contents remain drainable.
- Reset mid-operation: everything returns to reset values immediately; buffered data is lost.
- instr_data and instr_pc are stable while instr_valid && !instr_ready.

Decomposition:
- Shared macros header holds:
  - State encodings FETCH_IDLE and FETCH_RUN.
  - Default RESET_PC.
  - NOP encoding 32'h0000_0013 for decode-side bubbles.
- One sub-module: fetch_fifo, parameterised on DEPTH and width 64 ({pc, instr}). Ports: push, pop, flush, din, dout, count, empty, full.

Test Plan:
- Memory preloaded word[0]=32'h002081B3, word[4]=32'h402081B3. Release rst with fetch_en=1 and instr_ready=1 → mem_rd pulses at PC 0, 4, 8…; instr_valid in cycle 3 with {pc=0, data=32'h002081B3}, next cycle {pc=4, data=32'h402081B3}.
- Hold instr_ready=0 → exactly DEPTH+0 reads complete. count==2, mem_rd stays 0, head stays pc=0. Raise instr_ready → resumes one per cycle with no skipped or duplicated PC.
- Pulse redirect_valid with redirect_pc=32'h10 while one read is in flight and the FIFO holds 1 entry → instr_valid 0 next cycle; the in-flight word never appears; next delivered instr_pc=32'h10.
- Two consecutive redirect pulses (to 32'h8, then 32'h20) → first delivered instr_pc=32'h20.
- Drop fetch_en for 3 cycles mid-stream → no mem_rd during those cycles; buffered instructions drain in order; fetch restarts at the correct next PC.
- Assert rst asynchronously between clock edges with FIFO full → instr_valid and mem_rd go 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ------------------------------------------------------------------
// fetch_unit_pkg : shared state encodings and constants for fetch
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam int          FIFO_WIDTH       = 64;

   typedef enum logic [0:0] {
      FETCH_IDLE = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ------------------------------------------------------------------
// fetch_fifo : circular prefetch buffer of {pc, instr} entries
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a simultaneous pop frees the slot a push at full needs
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ------------------------------------------------------------------
// fetch_unit : PC generation, memory read issue, prefetch to decode
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] mem_pc,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int CW  = $clog2(DEPTH+1);
   localparam int CW1 = CW + 1;

   fetch_state_t state;
   fetch_state_t state_next;

   logic [31:0]         fetch_pc;
   logic [31:0]         inflight_pc;
   logic                inflight;
   logic [CW-1:0]       count;
   logic                empty;
   logic                full;
   logic [FIFO_WIDTH-1:0] head;
   logic                pop;
   logic                push;
   logic                issue;
   logic [CW1-1:0]      credit;

   assign pop    = instr_valid && instr_ready;
   // pop only happens with count >= 1, so this never underflows
   assign credit = {1'b0, count} + CW1'(inflight) - CW1'(pop);
   assign push   = inflight && !redirect_valid;

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         FETCH_IDLE: if (fetch_en)  state_next = FETCH_RUN;
         FETCH_RUN:  if (!fetch_en) state_next = FETCH_IDLE;
         default:    state_next = FETCH_IDLE;
      endcase
      issue = (state == FETCH_RUN) && fetch_en && !redirect_valid
              && (credit < CW1'(DEPTH)) && (!full || pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH_IDLE;
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state    <= state_next;
         inflight <= issue;
         if (issue) inflight_pc <= fetch_pc;
         if (redirect_valid) fetch_pc <= redirect_pc;
         else if (issue)     fetch_pc <= fetch_pc + PC_STEP;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FIFO_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({inflight_pc, mem_rdata}),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   assign mem_pc      = fetch_pc;
   assign mem_rd      = issue;
   assign mem_wr      = 1'b0;
   assign mem_wdata   = '0;
   assign instr_valid = !empty;
   assign instr_pc    = head[63:32];
   assign instr_data  = head[31:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ------------------------------------------------------------------
// tb_fetch_unit : scoreboard bench for fetch_unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] mem_pc;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int n_vec   = 0;
   int n_err   = 0;
   int n_deliv = 0;
   int d0;
   logic [63:0] sb_q[$];

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_pc         (mem_pc),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      if (pc == 32'h0) return 32'h0020_81B3;
      if (pc == 32'h4) return 32'h4020_81B3;
      return pc ^ 32'hC0DE_0000;
   endfunction

   // one-cycle synchronous read memory
   always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_pc) : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic expect_stream(input logic [31:0] start);
      logic [31:0] p;
      p = start;
      sb_q.delete();
      for (int i = 0; i < 64; i++) begin
         sb_q.push_back({p, mem_word(p)});
         p = p + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && !redirect_valid && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) check("sb_underrun", 64'(sb_q.size()), 64'd1);
         else check("deliver", {instr_pc, instr_data}, sb_q.pop_front());
         n_deliv++;
      end
   end

   initial begin
      rst = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) step();
      @(negedge clk);
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_rd",    64'(mem_rd),      64'd0);
      check("rst_wr",    64'(mem_wr),      64'd0);
      check("rst_wdata", 64'(mem_wdata),   64'd0);
      check("rst_idata", 64'(instr_data),  64'd0);
      check("rst_ipc",   64'(instr_pc),    64'd0);
      check("rst_mempc", 64'(mem_pc),      64'd0);

      // release and first-fetch latency
      step(); rst = 1'b0; expect_stream(32'h0);
      @(negedge clk); check("c0_rd", 64'(mem_rd), 64'd0);
      @(negedge clk); check("c1_rd", 64'(mem_rd), 64'd1); check("c1_pc", 64'(mem_pc), 64'h0);
      @(negedge clk); check("c2_valid", 64'(instr_valid), 64'd0); check("c2_pc", 64'(mem_pc), 64'h4);
      @(negedge clk); check("c3_valid", 64'(instr_valid), 64'd1); check("c3_ipc", 64'(instr_pc), 64'h0);
      @(negedge clk); check("c4_ipc", 64'(instr_pc), 64'h4);
      repeat (4) step();

      // backpressure: buffer fills to DEPTH, issue stops, head holds
      instr_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("bp_rd",   64'(mem_rd),   64'd0);
         check("bp_head", 64'(instr_pc), 64'(sb_q[0][63:32]));
      end
      check("bp_count", 64'(dut.u_fifo.count), 64'(DEPTH));
      step(); instr_ready = 1'b1;
      d0 = n_deliv;
      repeat (6) step();
      check("bp_resume", 64'(n_deliv - d0), 64'd6);

      // redirect with one entry buffered and one read in flight
      check("rd_pre_count", 64'(dut.u_fifo.count), 64'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h10; expect_stream(32'h10);
      @(negedge clk); check("r_rd", 64'(mem_rd), 64'd0);
      step(); redirect_valid = 1'b0;
      @(negedge clk);
      check("r1_valid", 64'(instr_valid), 64'd0);
      check("r1_rd",    64'(mem_rd),      64'd1);
      check("r1_pc",    64'(mem_pc),      64'h10);
      repeat (6) step();

      // back-to-back redirects, last wins
      redirect_valid = 1'b1; redirect_pc = 32'h8; expect_stream(32'h8);
      step(); redirect_pc = 32'h20; expect_stream(32'h20);
      step(); redirect_valid = 1'b0;
      @(negedge clk);
      check("rr_pc",    64'(mem_pc),      64'h20);
      check("rr_valid", 64'(instr_valid), 64'd0);
      d0 = n_deliv;
      repeat (6) step();
      check("rr_deliv", 64'(n_deliv - d0 >= 3), 64'd1);

      // fetch_en low for three cycles
      fetch_en = 1'b0;
      repeat (3) begin
         @(negedge clk); check("en_off_rd", 64'(mem_rd), 64'd0);
      end
      step(); fetch_en = 1'b1;
      @(negedge clk); check("en_idle_rd", 64'(mem_rd), 64'd0);
      check("en_drained", 64'(instr_valid), 64'd0);
      @(negedge clk); check("en_restart_rd", 64'(mem_rd), 64'd1);
      check("en_restart_pc", 64'(mem_pc), 64'(sb_q[0][63:32]));
      repeat (6) step();

      // PC wrap through 2^32
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; expect_stream(32'hFFFF_FFF8);
      step(); redirect_valid = 1'b0;
      d0 = n_deliv;
      repeat (8) step();
      check("wrap_deliv", 64'(n_deliv - d0 >= 4), 64'd1);

      // asynchronous reset with full buffer
      instr_ready = 1'b0;
      repeat (4) step();
      @(negedge clk); check("ar_full", 64'(dut.u_fifo.count), 64'(DEPTH));
      #2 rst = 1'b1;
      #1;
      check("ar_valid", 64'(instr_valid), 64'd0);
      check("ar_rd",    64'(mem_rd),      64'd0);
      check("ar_ipc",   64'(instr_pc),    64'd0);
      sb_q.delete();
      step(); step();
      instr_ready = 1'b1; rst = 1'b0; expect_stream(32'h0);
      @(negedge clk); check("ar_c0_rd", 64'(mem_rd), 64'd0);
      @(negedge clk); check("ar_c1_rd", 64'(mem_rd), 64'd1); check("ar_c1_pc", 64'(mem_pc), 64'h0);
      d0 = n_deliv;
      repeat (6) step();
      check("ar_deliv", 64'(n_deliv - d0 >= 4), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
